mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Shared data-memory responder on the far end of the core memory handshake (request/wren/address/writedata -> response/readdata).
- Arbitrates round-robin among NUM_CORES cores and serves one access at a time from an internal single-port word RAM.
- Issues the one-cycle response pulse each core waits on before leaving its memory-stall state.

Parameters:
- WIDTH, 32, data and address word width.
- NUM_CORES, 4, number of requesting cores.
- CORE_IDX, 2, index width; must equal clog2(NUM_CORES).
- ADDR_BITS, 10, RAM depth is 2**ADDR_BITS words.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- request  input  NUM_CORES  per-core level request; held high until that core samples its response.
- wren  input  NUM_CORES  per-core access type: 1 = write, 0 = read.
- address  input  NUM_CORES*WIDTH  per-core word address; core i uses slice [i*WIDTH +: WIDTH].
- writedata  input  NUM_CORES*WIDTH  per-core write data, same slicing.
- response  output  NUM_CORES  per-core one-cycle completion pulse.
- readdata  output  NUM_CORES*WIDTH  per-core registered read data, same slicing.
- busy  output  1  high while in ACCESS or RESPOND.
- grant_idx  output  CORE_IDX  index of the core being served or last served.

Behaviour:
- Reset (asynchronous):
  - state = IDLE, response = 0, readdata = 0, busy = 0, grant_idx = 0, priority pointer = 0.
  - RAM contents are not cleared.
- State machine: IDLE -> ACCESS -> RESPOND -> IDLE, one edge per transition.
- IDLE:
  - If any request bit is high at the edge, grant the first requesting core searching upward from the pointer, modulo NUM_CORES.
  - On grant: latch that core's wren, address[ADDR_BITS-1:0] and writedata; set grant_idx; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS edge:
  - Write: mem[addr] <= wdata, and the granted readdata slice <= wdata.
  - Read: the granted readdata slice <= mem[addr].
  - Set response[grant] = 1; go to RESPOND.
- RESPOND edge:
  - Clear response; pointer <= grant+1, wrapping NUM_CORES-1 -> 0; go to IDLE.
  - Arbitration never runs in RESPOND. This acts as the mandatory mask: the served core still drives request high at this edge and must not be re-granted.
- Latency and throughput:
  - Request sampled at edge E0; response high from E1 to E2 with readdata valid in that window.
  - At most one access per 3 cycles.
- Address bits above ADDR_BITS are ignored, so addresses alias modulo the RAM depth.
- readdata slices of non-granted cores hold their last value. A slice changes only at its own core's ACCESS edge.
- A request that drops before being granted is simply not served. No error is raised.
- Simultaneous requests from all cores: served in pointer order. Each waiting core is guaranteed service within NUM_CORES grants.
- Reset during ACCESS: the write is not committed and no response is issued.
- Reset during RESPOND: response drops immediately; the write has already been committed.
- Read-after-write to the same address by different cores returns the new data. There is no bypass concern because accesses are serialised.
- At most one response bit is high in any cycle.

Test Plan:
- Reset, then core 0 writes 0xDEADBEEF to address 5:
  - response[0] pulses exactly 1 cycle, 2 cycles after request.
  - readdata slice 0 = 0xDEADBEEF.
  - RAM[5] = 0xDEADBEEF.
- Core 2 reads address 5 after the previous write:
  - response[2] is a single pulse.
  - readdata slice 2 = 0xDEADBEEF.
  - Slices 0, 1 and 3 are unchanged.
- Cores 0-3 all request reads, held until their responses; pointer = 0:
  - grant order 0, 1, 2, 3; responses 3 cycles apart.
  - No core is granted twice.
- Core 1 holds request high for one cycle after its response, while core 3 also requests:
  - Core 1 is not re-served; core 3 is granted next.
  - Core 1 is served again only if it re-raises request.
- Core 0 writes 0x12345678 to address 0x405 (ADDR_BITS=10), then reads address 5:
  - The read returns 0x12345678, showing aliasing.
- Reset asserted while in ACCESS for a write of 0xAAAA5555 to address 7:
  - response stays 0 and state returns to IDLE.
  - RAM[7] keeps its prior value.

Source files
------------

// File: rtl/mem_responder_if.sv
// Core-side memory handshake bundle between the requesting cores and the shared responder.
// Per-core fields are packed side by side: core i uses slice [i*WIDTH +: WIDTH].
interface mem_responder_if #(
    parameter int WIDTH     = 32,
    parameter int NUM_CORES = 4,
    parameter int CORE_IDX  = 2
);
    logic [NUM_CORES-1:0]       request;
    logic [NUM_CORES-1:0]       wren;
    logic [NUM_CORES*WIDTH-1:0] address;
    logic [NUM_CORES*WIDTH-1:0] writedata;
    logic [NUM_CORES-1:0]       response;
    logic [NUM_CORES*WIDTH-1:0] readdata;
    logic                       busy;
    logic [CORE_IDX-1:0]        grant_idx;

    modport master (
        output request, wren, address, writedata,
        input  response, readdata, busy, grant_idx
    );

    modport slave (
        input  request, wren, address, writedata,
        output response, readdata, busy, grant_idx
    );
endinterface

// File: rtl/mem_responder.sv
// Shared word-RAM responder: round-robin arbitration among the cores, one access
// per three cycles, one-cycle response pulse to the served core.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | arbitrate among pending requests, latch the winner's access
// S_ACCESS  | perform read/write, update winner's readdata, pulse response
// S_RESPOND | clear response, advance pointer; no arbitration (masks winner)
module mem_responder #(
    parameter int WIDTH     = 32,
    parameter int NUM_CORES = 4,
    parameter int CORE_IDX  = 2,
    parameter int ADDR_BITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CORE_IDX-1:0]        ptr_q, ptr_d;
    logic [CORE_IDX-1:0]        grant_q, grant_d;
    logic                       wren_q, wren_d;
    logic [ADDR_BITS-1:0]       addr_q, addr_d;
    logic [WIDTH-1:0]           wdata_q, wdata_d;
    logic [NUM_CORES-1:0]       response_q, response_d;
    logic [NUM_CORES*WIDTH-1:0] readdata_q, readdata_d;

    logic [WIDTH-1:0]           mem [2**ADDR_BITS];
    logic [WIDTH-1:0]           mem_rdata;
    logic                       mem_we;

    logic                       found;
    logic [CORE_IDX-1:0]        pick;
    logic [CORE_IDX-1:0]        cand;

    // First requester at or above the pointer, wrapping modulo NUM_CORES.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = CORE_IDX'((int'(ptr_q) + k) % NUM_CORES);
            if (!found && bus.request[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign mem_rdata = mem[addr_q];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        wren_d     = wren_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        response_d = response_q;
        readdata_d = readdata_q;
        mem_we     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    wren_d  = bus.wren[pick];
                    addr_d  = bus.address[pick*WIDTH +: ADDR_BITS];
                    wdata_d = bus.writedata[pick*WIDTH +: WIDTH];
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_we                             = wren_q;
                readdata_d[grant_q*WIDTH +: WIDTH] = wren_q ? wdata_q : mem_rdata;
                response_d                         = '0;
                response_d[grant_q]                = 1'b1;
                state_d                            = S_RESPOND;
            end
            S_RESPOND: begin
                response_d = '0;
                ptr_d      = (grant_q == CORE_IDX'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            response_q <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            response_q <= response_d;
            readdata_q <= readdata_d;
        end
    end

    // RAM is deliberately not reset; a reset landing on ACCESS must not commit the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.response  = response_q;
    assign bus.readdata  = readdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.grant_idx = grant_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, multi-cycle corner
// sequences and randomized traffic against a transaction-timed reference model.
module tb_mem_responder;
    localparam int WIDTH     = 32;
    localparam int NUM_CORES = 4;
    localparam int CORE_IDX  = 2;
    localparam int ADDR_BITS = 10;
    localparam int DEPTH     = 1 << ADDR_BITS;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_responder_if #(.WIDTH(WIDTH), .NUM_CORES(NUM_CORES), .CORE_IDX(CORE_IDX)) bus ();

    mem_responder #(
        .WIDTH(WIDTH), .NUM_CORES(NUM_CORES), .CORE_IDX(CORE_IDX), .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             wr;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } op_t;

    typedef struct {
        int               core;
        logic             wr;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] exp_rd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: memory contents plus the timing of the current transaction
    logic [WIDTH-1:0]     m_mem [DEPTH];
    bit                   m_known [DEPTH];
    logic [WIDTH-1:0]     m_rd [NUM_CORES];
    bit                   m_rd_known [NUM_CORES];
    logic [NUM_CORES-1:0] m_resp;
    int                   m_ptr, m_grant, m_gedge;
    op_t                  m_op;
    int                   edge_n = 0;

    // core-side behaviour
    op_t q [NUM_CORES][$];
    int  hold [NUM_CORES];
    int  extra [NUM_CORES];
    int  gap [NUM_CORES];
    int  raise_edge [NUM_CORES];
    int  lat [NUM_CORES];
    int  resp_cnt [NUM_CORES];
    bit  rnd_mode = 0;

    int  grant_log [$];
    int  resp_log [$];
    bit  prev_busy = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic bit model_busy();
        return (edge_n == m_gedge) || (edge_n == m_gedge + 1);
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_grant = 0;
        m_gedge = -100;
        m_resp  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            m_rd[i]       = '0;
            m_rd_known[i] = 1;
        end
    endtask

    // A grant at edge G: data/response at G+1, pointer moves at G+2, next grant at G+3 or later.
    task automatic model_edge();
        int a;
        bit got;
        if (edge_n == m_gedge + 1) begin
            a = int'(m_op.addr % DEPTH);
            if (m_op.wr) begin
                m_mem[a]            = m_op.data;
                m_known[a]          = 1;
                m_rd[m_grant]       = m_op.data;
                m_rd_known[m_grant] = 1;
            end else begin
                m_rd[m_grant]       = m_mem[a];
                m_rd_known[m_grant] = m_known[a];
            end
            m_resp = NUM_CORES'(1) << m_grant;
        end else if (edge_n == m_gedge + 2) begin
            m_resp = '0;
            m_ptr  = (m_grant + 1) % NUM_CORES;
        end else if (edge_n >= m_gedge + 3) begin
            got = 0;
            for (int k = 0; k < NUM_CORES; k++) begin
                int c;
                c = (m_ptr + k) % NUM_CORES;
                if (!got && bus.request[c]) begin
                    got       = 1;
                    m_grant   = c;
                    m_gedge   = edge_n;
                    m_op.wr   = bus.wren[c];
                    m_op.addr = bus.address[c*WIDTH +: WIDTH];
                    m_op.data = bus.writedata[c*WIDTH +: WIDTH];
                end
            end
        end
    endtask

    task automatic compare_all();
        check("response", bus.response, m_resp);
        check("busy", bus.busy, model_busy());
        check("grant_idx", bus.grant_idx, m_grant);
        check("response_onehot0", $onehot0(bus.response), 1);
        for (int i = 0; i < NUM_CORES; i++)
            if (m_rd_known[i])
                check($sformatf("readdata[%0d]", i), bus.readdata[i*WIDTH +: WIDTH], m_rd[i]);
    endtask

    task automatic drive_op(int i, op_t op);
        bus.wren[i]                      = op.wr;
        bus.address[i*WIDTH +: WIDTH]    = op.addr;
        bus.writedata[i*WIDTH +: WIDTH]  = op.data;
        bus.request[i]                   = 1'b1;
        raise_edge[i]                    = edge_n;
    endtask

    task automatic core_update();
        op_t op;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (bus.request[i]) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) begin
                        bus.request[i] = 1'b0;
                        gap[i]         = 1;
                    end
                end else if (bus.response[i]) begin
                    hold[i] = 1 + extra[i];
                    lat[i]  = edge_n - raise_edge[i];
                end else if (rnd_mode && !(model_busy() && m_grant == i) &&
                             $urandom_range(0, 19) == 0) begin
                    bus.request[i] = 1'b0;
                    gap[i]         = 1;
                end
            end else if (gap[i] > 0) begin
                gap[i]--;
            end else if (q[i].size() > 0) begin
                op = q[i].pop_front();
                drive_op(i, op);
            end else if (rnd_mode && $urandom_range(0, 2) == 0) begin
                op.wr   = 1'($urandom_range(0, 1));
                op.addr = ($urandom & 32'hFFFF_FC00) | WIDTH'($urandom_range(0, 31));
                op.data = $urandom;
                drive_op(i, op);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (reset) model_reset();
        else model_edge();
        #1;
        compare_all();
        for (int i = 0; i < NUM_CORES; i++)
            if (bus.response[i]) resp_cnt[i]++;
        if (|bus.response && !past_resp_seen()) resp_log.push_back(edge_n);
        if (bus.busy && !prev_busy) grant_log.push_back(int'(bus.grant_idx));
        prev_busy = bus.busy;
        core_update();
    endtask

    // the response pulse is one cycle, so every cycle it is high starts a new pulse
    function automatic bit past_resp_seen();
        return 0;
    endfunction

    function automatic bit pending();
        bit p;
        p = model_busy() || (|bus.request) || bus.busy;
        for (int i = 0; i < NUM_CORES; i++)
            if (q[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drain(string name, int max_cycles);
        int cnt;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (pending() && cnt < max_cycles);
        check({name, "_drained"}, pending(), 0);
    endtask

    task automatic clear_cores();
        bus.request = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            q[i].delete();
            hold[i] = 0;
            gap[i]  = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_cores();
        #1;
        check("reset_response", bus.response, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_grant", bus.grant_idx, 0);
        check("reset_readdata", bus.readdata == '0, 1);
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic single(int core, bit wr, logic [WIDTH-1:0] addr, logic [WIDTH-1:0] data);
        op_t op;
        op.wr   = wr;
        op.addr = addr;
        op.data = data;
        q[core].push_back(op);
    endtask

    vec_t vecs [8];
    op_t  op;
    int   bound;

    initial begin
        vecs[0] = '{0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{2, 1'b0, 32'h0000_0005, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{0, 1'b1, 32'h0000_0405, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{0, 1'b0, 32'h0000_0005, 32'h0,         32'h1234_5678};
        vecs[4] = '{1, 1'b1, 32'h0000_0007, 32'h7777_7777, 32'h7777_7777};
        vecs[5] = '{3, 1'b1, 32'hFFFF_F3FF, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[6] = '{1, 1'b0, 32'h0000_03FF, 32'h0,         32'hCAFE_F00D};
        vecs[7] = '{2, 1'b0, 32'h0000_0007, 32'h0,         32'h7777_7777};

        bus.request   = '0;
        bus.wren      = '0;
        bus.address   = '0;
        bus.writedata = '0;
        for (int a = 0; a < DEPTH; a++) m_known[a] = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            hold[i] = 0; extra[i] = 0; gap[i] = 0; lat[i] = 0; resp_cnt[i] = 0;
        end
        model_reset();
        #2;
        check("init_response", bus.response, 0);
        check("init_busy", bus.busy, 0);
        step();
        step();
        reset = 1'b0;

        // directed single-core table
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                resp_cnt[i] = 0;
                lat[i]      = -1;
            end
            single(vecs[v].core, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            drain($sformatf("vec%0d", v), 20);
            check($sformatf("vec%0d_latency", v), lat[vecs[v].core], 2);
            check($sformatf("vec%0d_pulses", v), resp_cnt[vecs[v].core], 1);
            check($sformatf("vec%0d_readdata", v),
                  bus.readdata[vecs[v].core*WIDTH +: WIDTH], vecs[v].exp_rd);
        end

        // all cores at once from pointer 0
        do_reset();
        grant_log.delete();
        resp_log.delete();
        single(0, 1'b0, 32'h5, 32'h0);
        single(1, 1'b0, 32'h3FF, 32'h0);
        single(2, 1'b0, 32'h7, 32'h0);
        single(3, 1'b0, 32'h405, 32'h0);
        drain("all4", 40);
        check("all4_grants", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check($sformatf("all4_order%0d", k), grant_log[k], k);
        check("all4_resps", resp_log.size(), 4);
        for (int k = 1; k < 4 && k < resp_log.size(); k++)
            check($sformatf("all4_spacing%0d", k), resp_log[k] - resp_log[k-1], 3);
        check("all4_rd3", bus.readdata[3*WIDTH +: WIDTH], 32'h1234_5678);

        // core 1 lingers one cycle past its response while core 3 waits
        grant_log.delete();
        extra[1] = 1;
        single(1, 1'b0, 32'h7, 32'h0);
        single(3, 1'b0, 32'h5, 32'h0);
        drain("linger", 30);
        extra[1] = 0;
        check("linger_grants", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("linger_first", grant_log[0], 1);
            check("linger_second", grant_log[1], 3);
        end
        single(1, 1'b0, 32'h405, 32'h0);
        drain("reraise", 20);
        check("reraise_grants", grant_log.size(), 3);
        if (grant_log.size() >= 3) check("reraise_core", grant_log[2], 1);

        // reset while a write sits in ACCESS
        single(0, 1'b1, 32'h7, 32'hAAAA_5555);
        bound = 0;
        do begin
            step();
            bound++;
        end while (!model_busy() && bound < 10);
        check("acc_reached", bus.busy, 1);
        do_reset();
        check("acc_no_response", bus.response, 0);
        single(2, 1'b0, 32'h7, 32'h0);
        drain("acc_readback", 20);
        check("acc_ram7_kept", bus.readdata[2*WIDTH +: WIDTH], 32'h7777_7777);

        // reset while in RESPOND: pulse drops at once, write already committed
        single(1, 1'b1, 32'h9, 32'h0000_0055);
        bound = 0;
        do begin
            step();
            bound++;
        end while (m_resp == '0 && bound < 10);
        check("rsp_reached", bus.response, 4'b0010);
        do_reset();
        single(3, 1'b0, 32'h409, 32'h0);
        drain("rsp_readback", 20);
        check("rsp_ram9_written", bus.readdata[3*WIDTH +: WIDTH], 32'h0000_0055);

        // randomized traffic
        rnd_mode = 1;
        for (int c = 0; c < 600; c++) step();
        rnd_mode = 0;
        drain("random", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
